fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage of the RV32I core. Sits directly upstream of the main decoder and ALU decoder, which take op/funct3/funct7b5 from Instr.
- Owns the program counter and issues word requests to instruction memory over a valid/ready request and response handshake.
- Holds one fetched instruction in an output slot for decode. Prefetches the sequential next instruction.
- Applies redirects (PCSrc/PCTarget) from the execute path, discarding wrong-path fetches.

Parameters:
- XLEN, 32, data and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value of Instr while no instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  single core clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high.
- imem_req_valid  output  1  request to instruction memory.
- imem_req_ready  input  1  memory accepts the request.
- imem_addr  output  XLEN  word address of the request (bits [1:0] = 0).
- imem_rsp_valid  input  1  memory response available; held until accepted.
- imem_rsp_ready  output  1  fetch unit accepts the response.
- imem_rsp_data  input  32  fetched instruction word.
- instr_valid  output  1  Instr/PC hold a valid instruction.
- instr_ready  input  1  decode consumes the held instruction this cycle.
- Instr  output  32  held instruction.
- PC  output  XLEN  address of Instr.
- PCPlus4  output  XLEN  PC + 4, combinational.
- PCSrc  input  1  redirect; sampled only when instr_valid & instr_ready.
- PCTarget  input  XLEN  redirect target; word-aligned.

Behaviour:
- Registers:
  - fetch_pc: next address to request.
  - inflight_pc.
  - state: S_REQ or S_WAIT.
  - kill flag.
  - output slot: instr_valid, Instr, PC.
- Reset:
  - state=S_REQ, fetch_pc=RESET_PC, kill=0.
  - instr_valid=0, Instr=NOP_INSTR, PC=RESET_PC.
  - imem_req_valid=0 and imem_rsp_ready=0 while reset is high.
  - First request is presented in the cycle after reset deasserts.
- Reset mid-operation:
  - The slot is dropped and any outstanding request is forgotten.
  - Instruction memory shares reset and drops its in-flight response.
- At most one outstanding memory request.
- S_REQ:
  - imem_req_valid=1, imem_addr=fetch_pc.
  - On handshake: inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4, state<=S_WAIT.
  - imem_addr may change while a request is unaccepted; memory samples it only on handshake.
- S_WAIT:
  - imem_req_valid=0.
  - imem_rsp_ready = kill | ~instr_valid | instr_ready.
  - On response handshake: state<=S_REQ.
  - If kill, or redirect in the same cycle, the data is discarded and kill<=0.
  - Otherwise Instr<=imem_rsp_data, PC<=inflight_pc, instr_valid<=1.
- Consume (instr_valid & instr_ready):
  - instr_valid<=0 and Instr<=NOP_INSTR, unless a response is captured in the same cycle.
  - Back-to-back throughput: an instruction consumed and the next captured in the same cycle keeps instr_valid=1.
- Redirect (consume & PCSrc):
  - fetch_pc<=PCTarget, overriding the +4 update.
  - If state==S_WAIT with no response accepted this cycle, kill<=1.
  - If a request handshake occurs in the same cycle, that request is wrong-path: kill<=1 and state<=S_WAIT.
  - If a response is accepted in the same cycle, it is discarded.
- Output slot:
  - Slot full with decode stalled and response pending: imem_rsp_ready=0; memory holds the response.
  - Instr/PC are stable while instr_valid & ~instr_ready.
- Arithmetic:
  - All PC adds are modulo 2^XLEN.
  - fetch_pc=32'hFFFF_FFFC wraps to 0 with no error.
- Latency: redirect-to-first-correct-instr_valid is at least 2 cycles with zero-wait memory: request cycle, then response capture.

Test Plan:
- Zero-wait memory, instr_ready=1, no redirect → imem_addr 0,4,8,…; first instr_valid with PC=0 two cycles after reset falls; steady-state one instruction every 2 cycles.
- imem_req_ready low 3 cycles, then high → imem_addr held at 0x0 throughout; single handshake; Instr equals memory word 0.
- Slot full (PC=0x10) with instr_ready=0 for 4 cycles, response for 0x14 pending → imem_rsp_ready=0; Instr/PC stable; on release 0x10 is consumed and 0x14 captured in the same cycle.
- Consume of 0x10 with PCSrc=1, PCTarget=0x100 while the 0x14 request is outstanding → 0x14 response discarded; next request addr 0x100; next valid PC=0x100.
- Redirect coincident with request handshake for 0x18 (target 0x40) → 0x18 response dropped; then request 0x40 is issued.
- Reset asserted while in S_WAIT with slot full → the next cycle shows instr_valid=0, Instr=0x00000013, imem_req_valid=0; after release the first request addr is RESET_PC.
- fetch_pc=0xFFFF_FFFC → the following request addr is 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
// Request and response each use a valid/ready handshake.
interface fetch_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rsp_valid;
   logic            imem_rsp_ready;
   logic [31:0]     imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_addr,
      output imem_rsp_ready,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      input  imem_rsp_ready,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, keeps one request outstanding to instruction memory,
// holds one instruction for decode and squashes wrong-path fetches on redirect.
module fetch_unit #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset,
   fetch_unit_if.master    imem,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     Instr,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] PCPlus4,
   input  logic            PCSrc,
   input  logic [XLEN-1:0] PCTarget
);

   typedef enum logic [0:0] {StReq, StWait} state_e;

   state_e          state_q;
   logic [XLEN-1:0] fetch_pc_q;
   logic [XLEN-1:0] inflight_pc_q;
   logic            kill_q;

   logic consume;
   logic redirect;
   logic req_hs;
   logic rsp_hs;

   assign consume  = instr_valid & instr_ready;
   assign redirect = consume & PCSrc;

   assign imem.imem_req_valid = ~reset & (state_q == StReq);
   assign imem.imem_addr      = fetch_pc_q;
   // A killed response is always drained, even with the slot full.
   assign imem.imem_rsp_ready = ~reset & (state_q == StWait) &
                                (kill_q | ~instr_valid | instr_ready);

   assign req_hs = imem.imem_req_valid & imem.imem_req_ready;
   assign rsp_hs = imem.imem_rsp_valid & imem.imem_rsp_ready;

   assign PCPlus4 = PC + XLEN'(4);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StReq;
         fetch_pc_q    <= RESET_PC;
         inflight_pc_q <= RESET_PC;
         kill_q        <= 1'b0;
         instr_valid   <= 1'b0;
         Instr         <= NOP_INSTR;
         PC            <= RESET_PC;
      end else begin
         if (consume) begin
            instr_valid <= 1'b0;
            Instr       <= NOP_INSTR;
         end
         unique case (state_q)
            StReq: begin
               if (req_hs) begin
                  inflight_pc_q <= fetch_pc_q;
                  fetch_pc_q    <= fetch_pc_q + XLEN'(4);
                  state_q       <= StWait;
                  // Request accepted alongside a redirect is already wrong-path.
                  kill_q        <= redirect;
               end
            end
            StWait: begin
               if (rsp_hs) begin
                  state_q <= StReq;
                  kill_q  <= 1'b0;
                  if (!(kill_q || redirect)) begin
                     Instr       <= imem.imem_rsp_data;
                     PC          <= inflight_pc_q;
                     instr_valid <= 1'b1;
                  end
               end else if (redirect) begin
                  kill_q <= 1'b1;
               end
            end
         endcase
         if (redirect) fetch_pc_q <= PCTarget;
      end
   end

endmodule
